dmem_resp: RTL
==============

Name: dmem_resp

Overview:
- Downstream neighbour of the data-memory request stage.
- Tracks outstanding data-bus transactions in issue order and consumes the bus read data and its `data_ok` strobe.
- Aligns and sign/zero-extends load data per the recorded width and byte offset, then delivers a registered result to the M/W pipeline register.
- Exposes `full`/`busy` so the hazard unit can stall issue.

Parameters:
- DEPTH, 2, maximum outstanding transactions; power of two, ≥2.
- TIMEOUT, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  a request was issued to the bus this cycle
- req_wr  in  1  1 = store, 0 = load
- req_width  in  2  00 none, 01 byte, 10 half, 11 word (same encoding as MemWidth)
- req_sign  in  1  1 = sign-extend load (LB/LH)
- req_offset  in  2  PhyAddr[1:0] of the request
- data_ok  in  1  bus completes the oldest outstanding transaction
- rdata  in  32  bus read data, valid with `data_ok`
- resp_valid  out  1  registered completion pulse
- resp_wr  out  1  completed transaction was a store
- resp_data  out  32  aligned/extended load result; 0 for stores
- full  out  1  count == DEPTH
- busy  out  1  count != 0
- bus_err  out  1  sticky watchdog error; tied 0 when the feature is absent

Behaviour:
- Reset (`rst` = 1 at posedge): count = 0, read/write pointers = 0, resp_valid = 0, resp_wr = 0, resp_data = 0, bus_err = 0.
  - Pending tags are discarded, including when reset occurs mid-transaction.
  - A `data_ok` arriving after reset is treated as spurious.
- Tag FIFO, DEPTH entries of {wr, width, sign, offset}:
  - Push when `req_valid` & `req_width` != 00 & !`full`.
  - A `req_valid` with width 00, or while `full`, is dropped. Upstream must not issue while `full`; the bench flags a violation.
- Pop when `data_ok` & count != 0. A `data_ok` with count == 0 is ignored: no response, no state change.
- Push and pop in the same cycle: count unchanged, both pointers advance.
  - `full` is evaluated from the registered count. When count == DEPTH, a push is rejected even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Latency: the result is registered. `resp_valid` = 1 exactly one cycle after a popping `data_ok`, otherwise 0. Back-to-back `data_ok` gives back-to-back `resp_valid`.
- Alignment uses the popped tag; sh = offset*8.
  - Byte: b = rdata[sh+7:sh]; result = sign ? {{24{b[7]}}, b} : {24'b0, b}.
  - Half, offset 00 uses rdata[15:0]; offset 10 uses rdata[31:16]; extended to 32 bits per sign.
  - Half at offset 01/11: result 32'h0.
  - Word, offset 00: result = rdata. Word at offset != 00: result 32'h0.
  - Store: resp_wr = 1, resp_data = 0.
- `full`/`busy` are combinational from the registered count.

Optional Feature:
- Macro: DMEM_RESP_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while `busy` and resets on every pop or when count == 0.
  - When it reaches TIMEOUT, `bus_err` sets and stays set until `rst`. The oldest tag is force-popped with resp_valid = 1, resp_data = 32'hDEADBEEF, preventing pipeline deadlock.
- Undefined: no counter; `bus_err` is constant 0; TIMEOUT is unused.

Decomposition:
- Shared package (`mem_pkg`) holds:
  - width encoding constants W_NONE, W_BYTE, W_HALF, W_WORD;
  - the tag struct typedef;
  - the 32'hDEADBEEF error constant.
- One sub-module, `load_align`: purely combinational {rdata, width, sign, offset} -> 32-bit result. It is reusable by the uncached path.
- The FIFO stays inline in `dmem_resp`.

Test Plan:
- Load byte, sign = 1, offset 11; data_ok with rdata = 32'h80_12_34_56 -> next cycle resp_valid = 1, resp_data = 32'hFFFFFF80.
- Load half, sign = 0, offset 10, rdata = 32'hBEEF_1234 -> resp_data = 32'h0000BEEF. Same at offset 01 -> resp_data = 32'h0.
- Issue store then word load back-to-back; data_ok on two consecutive cycles (rdata 32'h0, then 32'h12345678) -> resp_wr sequence 1, 0; resp_data 0, then 32'h12345678; full asserted after 2 pushes with none popped.
- With full = 1, pulse req_valid together with data_ok -> count goes 2 -> 1, third request dropped; data_ok while empty -> no resp_valid.
- Assert rst with 1 outstanding, then data_ok -> no resp_valid; all outputs 0.
- DMEM_RESP_TIMEOUT_EN, TIMEOUT = 8: issue load, withhold data_ok -> after 8 busy cycles bus_err = 1 (sticky), resp_data = 32'hDEADBEEF, busy = 0.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg                                                                  |
// | Shared definitions for the data-memory path: width encoding (same as     |
// | MemWidth), the outstanding-transaction tag record and the bus-error      |
// | filler word returned when a transaction is abandoned.                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package mem_pkg;

   localparam logic [1:0] W_NONE = 2'b00;
   localparam logic [1:0] W_BYTE = 2'b01;
   localparam logic [1:0] W_HALF = 2'b10;
   localparam logic [1:0] W_WORD = 2'b11;

   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   // Everything needed to finish a transaction once its data returns.
   typedef struct packed {
      logic       wr;
      logic [1:0] width;
      logic       sign;
      logic [1:0] offset;
   } tag_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_align                                                               |
// | Combinational load formatter: selects the addressed byte/half/word of    |
// | the bus read data and sign- or zero-extends it to 32 bits. Misaligned    |
// | half/word accesses and width 00 yield 0.                                 |
// | Ports: rdata  - 32-bit bus read data                                     |
// |        width  - access width (W_NONE/W_BYTE/W_HALF/W_WORD)               |
// |        sign   - 1 = sign-extend                                          |
// |        offset - byte offset within the word (PhyAddr[1:0])               |
// |        result - aligned, extended load value                             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  width,
   input  logic        sign,
   input  logic [1:0]  offset,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (offset)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
   end

   // Only offsets 00 and 10 are legal for halves; offset[1] picks the half.
   assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      result = 32'h0;
      case (width)
         W_BYTE: result = {{24{sign & byte_sel[7]}}, byte_sel};
         W_HALF: if (!offset[0]) result = {{16{sign & half_sel[15]}}, half_sel};
         W_WORD: if (offset == 2'b00) result = rdata;
         default: result = 32'h0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_resp                                                                |
// | Data-memory response stage. Records each issued bus transaction in an    |
// | in-order tag FIFO, pops the oldest tag on data_ok, formats the load data |
// | and presents a registered completion to the M/W pipeline register.       |
// | Optional watchdog: define DMEM_RESP_TIMEOUT_EN to abandon a transaction  |
// | after TIMEOUT busy cycles without data_ok (sticky bus_err, 0xDEADBEEF).  |
// | Ports: clk, rst (sync, active-high)                                      |
// |        req_valid/req_wr/req_width/req_sign/req_offset - issued request   |
// |        data_ok/rdata - bus completion of oldest transaction              |
// |        resp_valid/resp_wr/resp_data - registered completion              |
// |        full/busy - occupancy for the hazard unit                         |
// |        bus_err - sticky watchdog error (0 without the watchdog)          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_resp
   import mem_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [1:0]  req_width,
   input  logic        req_sign,
   input  logic [1:0]  req_offset,
   input  logic        data_ok,
   input  logic [31:0] rdata,
   output logic        resp_valid,
   output logic        resp_wr,
   output logic [31:0] resp_data,
   output logic        full,
   output logic        busy,
   output logic        bus_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
      $error("dmem_resp: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   tag_t          fifo [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic          push;
   logic          data_pop;
   logic          timeout_hit;
   logic          pop;
   tag_t          head;
   tag_t          new_tag;
   logic [31:0]   aligned;

   // Occupancy comes from the registered count only, so a pop in the same
   // cycle never frees a slot for a push while full.
   assign full     = (count == CW'(DEPTH));
   assign busy     = (count != '0);
   assign push     = req_valid & (req_width != W_NONE) & ~full;
   assign data_pop = data_ok & busy;
   assign pop      = data_pop | timeout_hit;
   assign head     = fifo[rptr];
   assign new_tag  = '{wr: req_wr, width: req_width, sign: req_sign, offset: req_offset};

   // Tag storage needs no reset: pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) fifo[wptr] <= new_tag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   load_align u_align (
      .rdata  (rdata),
      .width  (head.width),
      .sign   (head.sign),
      .offset (head.offset),
      .result (aligned)
   );

`ifdef DMEM_RESP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wd_cnt;
   logic          err_flag;

   // wd_cnt holds the number of busy cycles already spent waiting, so the
   // TIMEOUT-th busy cycle without data_ok abandons the oldest transaction.
   assign timeout_hit = busy & ~data_ok & (wd_cnt == TW'(TIMEOUT - 1));
   assign bus_err     = err_flag;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt   <= '0;
         err_flag <= 1'b0;
      end else begin
         if (pop | ~busy) wd_cnt <= '0;
         else             wd_cnt <= wd_cnt + TW'(1);
         if (timeout_hit) err_flag <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_err     = 1'b0;
`endif

   // Result register: data holds between completions; stores report 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_wr    <= 1'b0;
         resp_data  <= 32'h0;
      end else begin
         resp_valid <= pop;
         if (pop) begin
            resp_wr <= head.wr;
            if (timeout_hit)  resp_data <= ERR_DATA;
            else if (head.wr) resp_data <= 32'h0;
            else              resp_data <= aligned;
         end
      end
   end

endmodule
`default_nettype wire
